// File: rtl/buffer_reg_pkg.sv
// rtl/buffer_reg_pkg.sv - shared RW encoding, op decode and sizing helper for buffer registers
package buffer_reg_pkg;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_OVF   = 3'd3,
        OP_UDF   = 3'd4
    } buf_op_e;

    // COUNT must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_storage_array.sv
// rtl/fifo_storage_array.sv - DEPTH x WIDTH register file, one sync write port, one async read port
module fifo_storage_array #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_buffer_register.sv
// rtl/fifo_buffer_register.sv - first-in first-out buffer register with count and error pulses
module fifo_buffer_register
    import buffer_reg_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             RW,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             EMPTY,
    output logic             FULL,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF,
    output logic             UDF
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_ovf;
    logic             r_udf;

    logic             w_empty;
    logic             w_full;
    logic [WIDTH-1:0] w_rd_data;
    buf_op_e          w_op;

    // Full/empty come from the count alone; pointer equality is ambiguous.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    always_comb begin
        w_op = OP_IDLE;
        if (EN) begin
            if (RW == RW_WRITE) begin
                w_op = w_full ? OP_OVF : OP_WRITE;
            end else begin
                w_op = w_empty ? OP_UDF : OP_READ;
            end
        end
    end

    fifo_storage_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .i_clk     (Clk),
        .i_wr_en   (w_op == OP_WRITE),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (dataIn),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_ovf <= (w_op == OP_OVF);
            r_udf <= (w_op == OP_UDF);
            case (w_op)
                OP_WRITE: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_count  <= r_count + CNT_W'(1);
                end
                OP_READ: begin
                    r_data_out <= w_rd_data;
                    r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                    r_count    <= r_count - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign dataOut = r_data_out;
    assign COUNT   = r_count;
    assign EMPTY   = w_empty;
    assign FULL    = w_full;
    assign OVF     = r_ovf;
    assign UDF     = r_udf;

endmodule

// File: tb/tb_fifo_buffer_register.sv
// tb/tb_fifo_buffer_register.sv - directed self-checking bench for fifo_buffer_register
module tb_fifo_buffer_register;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             EN = 1'b0;
    logic             RW = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic [WIDTH-1:0] dataOut;
    logic             EMPTY;
    logic             FULL;
    logic [3:0]       COUNT;
    logic             OVF;
    logic             UDF;

    int n_cmp = 0;
    int n_err = 0;

    fifo_buffer_register #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .EN      (EN),
        .RW      (RW),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .EMPTY   (EMPTY),
        .FULL    (FULL),
        .COUNT   (COUNT),
        .OVF     (OVF),
        .UDF     (UDF)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, let one rising edge take it, sample just after.
    task automatic step(input logic en, input logic rw, input logic [WIDTH-1:0] din);
        EN = en;
        RW = rw;
        dataIn = din;
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] din);
        step(1'b1, 1'b0, din);
    endtask

    task automatic rd();
        step(1'b1, 1'b1, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [3:0] fill_vals [4];
        logic [3:0] wrap_vals [5];
        fill_vals = '{4'h0, 4'h2, 4'h4, 4'h6};
        wrap_vals = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

        #100;
        check("rst_count", COUNT, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_dout", dataOut, 0);
        check("rst_ovf", OVF, 0);
        check("rst_udf", UDF, 0);
        Rst = 1'b1;
        #2;

        for (int i = 0; i < 4; i++) begin
            wr(fill_vals[i]);
            check("fill_cnt_up", COUNT, i + 1);
        end
        check("fill_not_empty", EMPTY, 0);
        for (int i = 0; i < 4; i++) begin
            rd();
            check("fill_order", dataOut, fill_vals[i]);
            check("fill_cnt_dn", COUNT, 3 - i);
        end
        check("fill_empty_end", EMPTY, 1);

        for (int i = 1; i <= 8; i++) begin
            wr(4'(i));
            check("full_cnt", COUNT, i);
        end
        check("full_flag", FULL, 1);
        check("full_ovf_quiet", OVF, 0);
        wr(4'hF);
        check("ovf_pulse", OVF, 1);
        check("ovf_cnt_held", COUNT, 8);
        check("ovf_full_held", FULL, 1);
        idle();
        check("ovf_one_cycle", OVF, 0);
        for (int i = 1; i <= 8; i++) begin
            rd();
            check("full_drain", dataOut, i);
            check("full_drain_cnt", COUNT, 8 - i);
        end
        check("full_cleared", FULL, 0);

        rd();
        check("udf_pulse", UDF, 1);
        check("udf_dout_held", dataOut, 8);
        check("udf_cnt", COUNT, 0);
        check("udf_empty", EMPTY, 1);
        idle();
        check("udf_one_cycle", UDF, 0);

        for (int i = 0; i < 6; i++) wr(4'(i + 1));
        check("wrap_cnt6", COUNT, 6);
        for (int i = 0; i < 6; i++) begin
            rd();
            check("wrap_first", dataOut, i + 1);
        end
        for (int i = 0; i < 5; i++) wr(wrap_vals[i]);
        check("wrap_cnt5", COUNT, 5);
        for (int i = 0; i < 5; i++) begin
            rd();
            check("wrap_order", dataOut, wrap_vals[i]);
        end
        check("wrap_empty", EMPTY, 1);

        wr(4'h7);
        wr(4'h9);
        wr(4'h5);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i), 4'(i * 3 + 1));
            check("hold_cnt", COUNT, 3);
            check("hold_dout", dataOut, 4'hE);
            check("hold_empty", EMPTY, 0);
            check("hold_full", FULL, 0);
            check("hold_ovf", OVF, 0);
            check("hold_udf", UDF, 0);
        end
        rd();
        check("hold_oldest", dataOut, 4'h7);
        check("hold_cnt_after", COUNT, 2);

        wr(4'h1);
        wr(4'h2);
        wr(4'h4);
        check("pre_rst_cnt", COUNT, 5);
        EN = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        check("arst_cnt", COUNT, 0);
        check("arst_empty", EMPTY, 1);
        check("arst_full", FULL, 0);
        check("arst_dout", dataOut, 0);
        @(posedge Clk);
        #3;
        Rst = 1'b1;
        #1;
        check("arst_rel_cnt", COUNT, 0);
        wr(4'h3);
        check("post_rst_cnt", COUNT, 1);
        rd();
        check("post_rst_read", dataOut, 4'h3);
        check("post_rst_empty", EMPTY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_buffer_register.md
Name: fifo_buffer_register

Overview:
- Companion to the LIFO buffer register, with the opposite retrieval order: data is read back first-in, first-out, from the end opposite to the write end.
- Same single-port-style control as the LIFO: one RW select plus EN, with EMPTY/FULL status.
- Adds a fill count and one-cycle overflow/underflow error pulses.
- Used as a drop-in elastic buffer wherever arrival order must be preserved.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of 2 and at least 2.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous reset, active-low (0 = reset asserted).
- EN  input  1  operation enable; 0 means no operation and all state holds.
- RW  input  1  0 = write (push at tail), 1 = read (pop from head); sampled only when EN=1.
- dataIn  input  WIDTH  write data.
- dataOut  output  WIDTH  registered read data.
- EMPTY  output  1  count == 0.
- FULL  output  1  count == DEPTH.
- COUNT  output  $clog2(DEPTH)+1  current number of stored entries.
- OVF  output  1  one-cycle pulse: a write was attempted while FULL.
- UDF  output  1  one-cycle pulse: a read was attempted while EMPTY.

Behaviour:
- Reset (Rst=0, asynchronous, takes effect without waiting for a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, dataOut=0.
  - EMPTY=1, FULL=0, OVF=0, UDF=0.
  - Storage contents are not cleared and are don't-care.
- Reset release: state is first updated on the first rising Clk edge after Rst returns to 1.
- State per rising Clk edge, priority in this order:
  - EN=0: nothing changes, dataOut holds, OVF=UDF=0.
  - EN=1, RW=0, FULL=0: mem[wr_ptr]<=dataIn; wr_ptr<=wr_ptr+1 mod DEPTH; count<=count+1.
  - EN=1, RW=0, FULL=1: write is dropped; pointers, count and memory unchanged; OVF=1 for this cycle only.
  - EN=1, RW=1, EMPTY=0: dataOut<=mem[rd_ptr]; rd_ptr<=rd_ptr+1 mod DEPTH; count<=count-1.
  - EN=1, RW=1, EMPTY=1: dataOut holds its last value; pointers unchanged; UDF=1 for this cycle only.
- Read latency:
  - dataOut is valid one edge after the read is sampled, and holds until the next successful read or reset.
  - A read never returns data written in the same edge; RW is a single bit, so a simultaneous read and write cannot occur.
- Flags:
  - EMPTY and FULL are decoded from the registered count, so they change on the same edge as count.
  - count is bounded to the range 0..DEPTH.
- Wrap-around:
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - Full/empty are distinguished by count, never by pointer equality.
- OVF and UDF are registered pulses asserted in the cycle after the offending edge; they are not sticky.
- Reset asserted mid-burst: the operation in progress is abandoned and all outputs take their reset values immediately.

Decomposition:
- Shared package buffer_reg_pkg holds:
  - RW_WRITE=1'b0 and RW_READ=1'b1, shared with the LIFO.
  - The function for COUNT width, $clog2(DEPTH)+1.
- Optional sub-module fifo_storage_array: DEPTH x WIDTH register file with one synchronous write port and one read port, no reset. The pointer, count and flag logic stays in the top module.

Test Plan:
- Fill order: Rst=0 for 100 ns, release, EN=1, RW=0, write 4'h0, 4'h2, 4'h4, 4'h6, then RW=1 for four reads.
  - Required: dataOut = 0, 2, 4, 6 in that order (the LIFO would give 6, 4, 2, 0).
  - COUNT goes 1, 2, 3, 4, then 3, 2, 1, 0; EMPTY=1 at the end.
- Full/overflow: write 4'h1 through 4'h8 (8 writes), then write 4'hF.
  - Required: FULL=1 and COUNT=8 after the 8th write.
  - OVF pulses for exactly 1 cycle; COUNT stays 8.
  - Eight subsequent reads return 1 through 8; 4'hF is never read.
- Underflow: from empty after the last read returned 4'h8, issue RW=1.
  - Required: UDF pulses for 1 cycle; dataOut stays 4'h8; COUNT=0; EMPTY=1.
- Wrap-around: write 6 / read 6, then write 5 more (4'hA..4'hE) and read 5.
  - Required: the pointers wrap past index 7 and reads return A, B, C, D, E in order.
- EN hold: with 3 entries stored, hold EN=0 for 5 cycles while toggling RW and dataIn.
  - Required: COUNT, dataOut and flags are unchanged; the next read returns the oldest entry.
- Async reset mid-operation: with 5 entries stored, assert Rst=0 between clock edges.
  - Required: COUNT=0, EMPTY=1, FULL=0 and dataOut=0 immediately, before the next edge.
  - After release, a write of 4'h3 followed by a read returns 4'h3.
